// File: rtl/checker_memory_pkg.sv
// Shared types and helpers for the checker byte memory: FSM encodings,
// default sizing and the Wishbone big-endian <-> memory little-endian lane swap.
`timescale 1ns/1ps
package checker_memory_pkg;

  typedef enum logic {
    CLR_CLEAR = 1'b0,
    CLR_RUN   = 1'b1
  } clr_state_t;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_WAIT = 2'd1,
    WB_ACK  = 2'd2
  } wb_state_t;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEPTH          = depth_of(DEF_ADDR_WIDTH);
  localparam int CLR_WORDS      = DEPTH / 4;

  // Byte 0 of the bus word (bits 31:24) maps to the lowest memory address.
  function automatic logic [31:0] lane_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [3:0] sel_swap(input logic [3:0] s);
    return {s[0], s[1], s[2], s[3]};
  endfunction

endpackage

// File: rtl/checker_memory_wb_fsm.sv
// Wishbone handshake for the checker memory: programmable ack latency,
// single-cycle ack/err pulse and the commit strobe that qualifies writes/reads.
`timescale 1ns/1ps
module checker_memory_wb_fsm
  import checker_memory_pkg::*;
#(
  parameter int WB_LATENCY = 1
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic run,
  input  logic req,
  input  logic addr_bad,
  output logic ack,
  output logic err,
  output logic commit
);

  localparam logic [2:0] LAT_M1 = 3'(WB_LATENCY - 1);

  wb_state_t  state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;
  logic       ack_reg, err_reg;
  logic       go_ack;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    go_ack     = 1'b0;
    case (state_reg)
      WB_IDLE: begin
        if (run && req) begin
          if (LAT_M1 == 3'd0) begin
            go_ack = 1'b1;
          end else begin
            state_next = WB_WAIT;
            cnt_next   = LAT_M1;
          end
        end
      end
      WB_WAIT: begin
        // A dropped strobe abandons the access silently.
        if (!req) begin
          state_next = WB_IDLE;
        end else if (cnt_reg <= 3'd1) begin
          go_ack = 1'b1;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      default: state_next = WB_IDLE;
    endcase
    if (go_ack) begin
      state_next = WB_ACK;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg <= WB_IDLE;
      cnt_reg   <= '0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ack_reg   <= go_ack && !addr_bad;
      err_reg   <= go_ack && addr_bad;
    end
  end

  assign ack    = ack_reg;
  assign err    = err_reg;
  assign commit = go_ack && !addr_bad && !sys_rst;

endmodule

// File: rtl/checker_memory_dp.sv
// Checker shared byte memory: Wishbone host port, registered MPU fetch port and
// post-reset clear sequencer. Define CHECKER_MEMORY_WB_ERR_EN to add wb_err_o.
`timescale 1ns/1ps
module checker_memory_dp
  import checker_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MPU_BYTES  = 6,
  parameter int WB_LATENCY = 1
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [15:0]            mpu_addr,
  input  logic                   mpu_req,
  output logic [8*MPU_BYTES-1:0] mpu_do,
  output logic                   mpu_valid,
  input  logic [31:0]            wb_adr_i,
  input  logic [31:0]            wb_dat_i,
  output logic [31:0]            wb_dat_o,
  input  logic [3:0]             wb_sel_i,
  input  logic                   wb_stb_i,
  input  logic                   wb_cyc_i,
  input  logic                   wb_we_i,
  output logic                   wb_ack_o,
`ifdef CHECKER_MEMORY_WB_ERR_EN
  output logic                   wb_err_o,
`endif
  output logic                   clr_busy
);

  localparam int MEM_DEPTH = depth_of(ADDR_WIDTH);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  localparam logic [ADDR_WIDTH-3:0] LAST_WORD = '1;

  logic [7:0] mem [MEM_DEPTH];

  clr_state_t            clr_state_reg, clr_state_next;
  logic [ADDR_WIDTH-3:0] clr_k_reg, clr_k_next;
  logic                  clr_run;

  addr_t       wb_base;
  addr_t       wb_lane_addr [4];
  logic [31:0] wb_wdata_le, wb_rdata_le;
  logic [3:0]  wb_sel_le;
  logic        wb_commit, wb_addr_bad, wb_err_int;

  addr_t                  mpu_lane_addr [MPU_BYTES];
  logic [8*MPU_BYTES-1:0] mpu_rdata;
  logic                   unused_bits;

  always_comb begin
    clr_state_next = clr_state_reg;
    clr_k_next     = clr_k_reg;
    if (clr_state_reg == CLR_CLEAR) begin
      clr_k_next = clr_k_reg + 1'b1;
      if (clr_k_reg == LAST_WORD) begin
        clr_state_next = CLR_RUN;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      clr_state_reg <= CLR_CLEAR;
      clr_k_reg     <= '0;
    end else begin
      clr_state_reg <= clr_state_next;
      clr_k_reg     <= clr_k_next;
    end
  end

  assign clr_run  = (clr_state_reg == CLR_RUN);
  assign clr_busy = (clr_state_reg == CLR_CLEAR);

  assign wb_base     = wb_adr_i[ADDR_WIDTH-1:0];
  assign wb_wdata_le = lane_swap(wb_dat_i);
  assign wb_sel_le   = sel_swap(wb_sel_i);

  // Lane addresses wrap naturally in ADDR_WIDTH-bit arithmetic.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_wb_lane
      assign wb_lane_addr[gi]        = wb_base + addr_t'(gi);
      assign wb_rdata_le[8*gi +: 8] = mem[wb_lane_addr[gi]];
    end
    for (genvar gi = 0; gi < MPU_BYTES; gi++) begin : g_mpu_lane
      assign mpu_lane_addr[gi]     = mpu_addr[ADDR_WIDTH-1:0] + addr_t'(gi);
      assign mpu_rdata[8*gi +: 8] = mem[mpu_lane_addr[gi]];
    end
  endgenerate

`ifdef CHECKER_MEMORY_WB_ERR_EN
  assign wb_addr_bad = (|wb_adr_i[31:ADDR_WIDTH]) || (wb_base > addr_t'(MEM_DEPTH - 4));
  assign wb_err_o    = wb_err_int;
  assign unused_bits = ^mpu_addr[15:ADDR_WIDTH];
`else
  assign wb_addr_bad = 1'b0;
  assign unused_bits = ^{mpu_addr[15:ADDR_WIDTH], wb_adr_i[31:ADDR_WIDTH], wb_err_int};
`endif

  checker_memory_wb_fsm #(
    .WB_LATENCY(WB_LATENCY)
  ) u_wb_fsm (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .run     (clr_run),
    .req     (wb_cyc_i & wb_stb_i),
    .addr_bad(wb_addr_bad),
    .ack     (wb_ack_o),
    .err     (wb_err_int),
    .commit  (wb_commit)
  );

  // Storage is not reset; the clear sequencer owns zeroing it.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst && clr_state_reg == CLR_CLEAR) begin
      for (int j = 0; j < 4; j++) begin
        mem[{clr_k_reg, 2'(j)}] <= '0;
      end
    end else if (wb_commit && wb_we_i) begin
      for (int j = 0; j < 4; j++) begin
        if (wb_sel_le[j]) begin
          mem[wb_lane_addr[j]] <= wb_wdata_le[8*j +: 8];
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wb_dat_o  <= '0;
      mpu_do    <= '0;
      mpu_valid <= 1'b0;
    end else begin
      if (wb_commit && !wb_we_i) begin
        wb_dat_o <= lane_swap(wb_rdata_le);
      end
      mpu_valid <= clr_run && mpu_req;
      if (clr_run && mpu_req) begin
        mpu_do <= mpu_rdata;
      end
    end
  end

endmodule

// File: tb/tb_checker_memory_dp.sv
// Directed bench for checker_memory_dp: one instance with ack latency 1 and one
// with latency 4, sharing address/data/MPU inputs but with separate cyc/stb/reset.
`timescale 1ns/1ps
module tb_checker_memory_dp;

  logic        sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        rst1, rst4;
  logic [15:0] mpu_addr;
  logic        mpu_req;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc1, stb1, cyc4, stb4;

  logic [47:0] mpu_do1, mpu_do4;
  logic        mpu_valid1, mpu_valid4;
  logic [31:0] dat_o1, dat_o4;
  logic        ack1, ack4, busy1, busy4;
  logic        err1, err4;

  int n_checks = 0;
  int n_fail   = 0;

  checker_memory_dp #(.ADDR_WIDTH(10), .MPU_BYTES(6), .WB_LATENCY(1)) dut1 (
    .sys_clk(sys_clk), .sys_rst(rst1),
    .mpu_addr(mpu_addr), .mpu_req(mpu_req), .mpu_do(mpu_do1), .mpu_valid(mpu_valid1),
    .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat_o1), .wb_sel_i(sel),
    .wb_stb_i(stb1), .wb_cyc_i(cyc1), .wb_we_i(we), .wb_ack_o(ack1),
`ifdef CHECKER_MEMORY_WB_ERR_EN
    .wb_err_o(err1),
`endif
    .clr_busy(busy1)
  );

  checker_memory_dp #(.ADDR_WIDTH(10), .MPU_BYTES(6), .WB_LATENCY(4)) dut4 (
    .sys_clk(sys_clk), .sys_rst(rst4),
    .mpu_addr(mpu_addr), .mpu_req(mpu_req), .mpu_do(mpu_do4), .mpu_valid(mpu_valid4),
    .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat_o4), .wb_sel_i(sel),
    .wb_stb_i(stb4), .wb_cyc_i(cyc4), .wb_we_i(we), .wb_ack_o(ack4),
`ifdef CHECKER_MEMORY_WB_ERR_EN
    .wb_err_o(err4),
`endif
    .clr_busy(busy4)
  );

`ifndef CHECKER_MEMORY_WB_ERR_EN
  assign err1 = 1'b0;
  assign err4 = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Full Wishbone transaction; returns read data, latency in cycles and err flag.
  task automatic wb_xfer(input int which, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] rd, output int lat, output logic er);
    logic done;
    adr = a; dat = d; sel = s; we = w;
    if (which == 1) begin cyc1 = 1'b1; stb1 = 1'b1; end
    else            begin cyc4 = 1'b1; stb4 = 1'b1; end
    lat  = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge sys_clk); #1;
      lat++;
      done = (which == 1) ? (ack1 | err1) : (ack4 | err4);
    end
    if (!done) lat = -1;
    rd = (which == 1) ? dat_o1 : dat_o4;
    er = (which == 1) ? err1 : err4;
    cyc1 = 1'b0; stb1 = 1'b0; cyc4 = 1'b0; stb4 = 1'b0;
    @(posedge sys_clk); #1;
    check("ack_single_cycle", (which == 1) ? ack1 : ack4, 1'b0);
  endtask

  task automatic mpu_fetch(input logic [15:0] a, output logic [47:0] d, output logic v);
    mpu_addr = a; mpu_req = 1'b1;
    @(posedge sys_clk); #1;
    d = mpu_do1; v = mpu_valid1;
    mpu_req = 1'b0;
  endtask

  task automatic count_busy(input int which, output int n, output int bad);
    logic b;
    n = 0; bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge sys_clk);
      b = (which == 1) ? busy1 : busy4;
      if (!b) break;
      n++;
      if ((which == 1) ? (mpu_valid1 | ack1) : (mpu_valid4 | ack4)) bad++;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [47:0] md, acc;
    logic        mv, er, seen;
    int          lat, n, bad, vcnt;

    rst1 = 1'b1; rst4 = 1'b1; mpu_addr = '0; mpu_req = 1'b0;
    adr = '0; dat = '0; sel = '0; we = 1'b0;
    cyc1 = 1'b0; stb1 = 1'b0; cyc4 = 1'b0; stb4 = 1'b0;

    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_ack", ack1, 1'b0);
    check("rst_dat_o", dat_o1, 32'h0);
    check("rst_mpu_valid", mpu_valid1, 1'b0);
    check("rst_mpu_do", mpu_do1, 48'h0);
    check("rst_clr_busy", busy1, 1'b1);

    // Release reset with an MPU request and a stalled WB write pending.
    rst1 = 1'b0; rst4 = 1'b0;
    mpu_addr = 16'h0100; mpu_req = 1'b1;
    adr = 32'h80; dat = 32'h5A5A5A5A; sel = 4'hF; we = 1'b1;
    cyc1 = 1'b1; stb1 = 1'b1;
    count_busy(1, n, bad);
    check("clear_cycles", n, 256);
    check("clear_no_valid_or_ack", bad, 0);
    @(posedge sys_clk); #1;
    check("stalled_strobe_acked", ack1, 1'b1);
    cyc1 = 1'b0; stb1 = 1'b0; mpu_req = 1'b0;
    @(posedge sys_clk); #1;

    // Back-to-back MPU sweep of dut4: every byte zero, one result per cycle.
    acc = '0; vcnt = 0;
    mpu_addr = 16'h0; mpu_req = 1'b1;
    for (int i = 1; i <= 171; i++) begin
      @(posedge sys_clk); #1;
      acc  = acc | mpu_do4;
      vcnt = vcnt + int'(mpu_valid4);
      mpu_addr = 16'(6 * i);
    end
    mpu_req = 1'b0;
    check("sweep_all_zero", acc, 48'h0);
    check("sweep_valid_count", vcnt, 171);

    mpu_fetch(16'h0080, md, mv);
    check("stalled_write_data", md, 48'h00005A5A5A5A);

    // Full-word write, latency 1.
    wb_xfer(1, 1'b1, 32'h10, 32'h11223344, 4'hF, rd, lat, er);
    check("wr10_latency", lat, 1);
    mpu_fetch(16'h0010, md, mv);
    check("mpu10_valid", mv, 1'b1);
    check("mpu10_data", md, 48'h000044332211);
    wb_xfer(1, 1'b0, 32'h10, 32'h0, 4'hF, rd, lat, er);
    check("rd10_data", rd, 32'h11223344);

    // Partial write: only lane sel[2] -> mem[0x11].
    wb_xfer(1, 1'b1, 32'h10, 32'hAABBCCDD, 4'h4, rd, lat, er);
    wb_xfer(1, 1'b0, 32'h10, 32'h0, 4'hF, rd, lat, er);
    check("rd10_partial", rd, 32'h11BB3344);

    // Wrapping access at the top of memory.
    wb_xfer(1, 1'b1, 32'h3FE, 32'hDEADBEEF, 4'hF, rd, lat, er);
    mpu_fetch(16'h03FE, md, mv);
`ifdef CHECKER_MEMORY_WB_ERR_EN
    check("wrap_err", er, 1'b1);
    check("wrap_mpu_unchanged", md, 48'h0);
`else
    check("wrap_latency", lat, 1);
    check("wrap_mpu_data", md, 48'h0000EFBEADDE);
    wb_xfer(1, 1'b0, 32'h3FE, 32'h0, 4'hF, rd, lat, er);
    check("wrap_rd_data", rd, 32'hDEADBEEF);
`endif

    // Collision: MPU read and WB commit on the same edge return old data.
    wb_xfer(1, 1'b1, 32'h20, 32'h01020304, 4'hF, rd, lat, er);
    adr = 32'h20; dat = 32'hA1B2C3D4; sel = 4'hF; we = 1'b1;
    cyc1 = 1'b1; stb1 = 1'b1;
    mpu_addr = 16'h0020; mpu_req = 1'b1;
    @(posedge sys_clk); #1;
    check("collide_ack", ack1, 1'b1);
    check("collide_old_data", mpu_do1, 48'h000004030201);
    cyc1 = 1'b0; stb1 = 1'b0;
    @(posedge sys_clk); #1;
    check("collide_new_data", mpu_do1, 48'h0000D4C3B2A1);
    mpu_req = 1'b0;
    @(posedge sys_clk); #1;
    check("idle_valid_low", mpu_valid1, 1'b0);
    check("idle_do_held", mpu_do1, 48'h0000D4C3B2A1);

    // Latency 4 instance.
    wb_xfer(4, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, rd, lat, er);
    check("lat4_write", lat, 4);
    wb_xfer(4, 1'b0, 32'h40, 32'h0, 4'hF, rd, lat, er);
    check("lat4_read_latency", lat, 4);
    check("lat4_read_data", rd, 32'hCAFEF00D);

    // Strobe withdrawn after two cycles: no ack, no write.
    adr = 32'h44; dat = 32'h12345678; sel = 4'hF; we = 1'b1;
    cyc4 = 1'b1; stb4 = 1'b1;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    cyc4 = 1'b0; stb4 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge sys_clk); #1;
      seen = seen | ack4;
    end
    check("drop_no_ack", seen, 1'b0);
    wb_xfer(4, 1'b0, 32'h44, 32'h0, 4'hF, rd, lat, er);
    check("drop_no_write", rd, 32'h0);

    // Reset pulsed while waiting: no ack, clear restarts from word 0.
    adr = 32'h48; dat = 32'h99999999; sel = 4'hF; we = 1'b1;
    cyc4 = 1'b1; stb4 = 1'b1;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    rst4 = 1'b1;
    @(posedge sys_clk); #1;
    rst4 = 1'b0; cyc4 = 1'b0; stb4 = 1'b0;
    check("rst_wait_no_ack", ack4, 1'b0);
    check("rst_wait_busy", busy4, 1'b1);
    count_busy(4, n, bad);
    check("reclear_cycles", n, 256);
    check("reclear_no_ack", bad, 0);
    @(posedge sys_clk); #1;
    wb_xfer(4, 1'b0, 32'h40, 32'h0, 4'hF, rd, lat, er);
    check("reclear_mem40", rd, 32'h0);
    wb_xfer(4, 1'b0, 32'h48, 32'h0, 4'hF, rd, lat, er);
    check("reclear_mem48", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/checker_memory_dp.md
Name: checker_memory_dp

Overview:
- Parametrised successor to the checker's shared byte memory: a byte-addressed RAM between the Wishbone bus (host loads checker programs and data) and the checker MPU (instruction and operand fetch).
- Adds over the previous generation:
  - configurable depth and MPU fetch width
  - registered MPU read port with request/valid handshake
  - programmable Wishbone ack latency
  - hardware clear sequencer after reset, instead of a one-cycle bulk clear

Parameters:
- ADDR_WIDTH, 10: memory holds 2**ADDR_WIDTH bytes; all addresses are taken modulo the depth.
- MPU_BYTES, 6: bytes returned per MPU fetch; range 1..8.
- WB_LATENCY, 1: cycles from first sampled strobe to wb_ack_o; range 1..7.

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous active-high reset
- mpu_addr  in  16  MPU byte address; low ADDR_WIDTH bits used
- mpu_req  in  1  MPU fetch request, sampled each cycle
- mpu_do  out  8*MPU_BYTES  fetched bytes; mpu_do[7:0] = mem[a+0]
- mpu_valid  out  1  mpu_do holds the fetch requested in the previous cycle
- wb_adr_i  in  32  Wishbone byte address; low ADDR_WIDTH bits used
- wb_dat_i  in  32  write data; big-endian lanes, wb_dat_i[31:24] goes to mem[a+0]
- wb_dat_o  out  32  read data; same lane order as wb_dat_i
- wb_sel_i  in  4  byte enables; wb_sel_i[3] gates mem[a+0], wb_sel_i[0] gates mem[a+3]
- wb_stb_i  in  1  strobe
- wb_cyc_i  in  1  cycle
- wb_we_i  in  1  write enable
- wb_ack_o  out  1  acknowledge
- clr_busy  out  1  clear sequencer running

Behaviour:
- Reset (synchronous, sys_rst high at a sys_clk edge):
  - Outputs: wb_ack_o=0, wb_dat_o=0, mpu_valid=0, mpu_do=0, clr_busy=1.
  - Aborts any Wishbone or MPU transaction in progress without committing it.
- Clear sequencer:
  - States: CLEAR and RUN.
  - CLEAR zeroes 4 bytes per cycle at word index k = 0 .. DEPTH/4-1, which takes DEPTH/4 cycles.
  - Enters RUN on the cycle after the last word is written; clr_busy then drops.
  - Reset asserted during CLEAR restarts from k=0.
- Wishbone FSM:
  - States: IDLE, WAIT, ACK.
  - IDLE to WAIT when wb_cyc_i&wb_stb_i and state is RUN; the latency counter loads WB_LATENCY-1.
  - WAIT counts down; at 0 it goes to ACK. With WB_LATENCY=1, WAIT lasts zero cycles and ack is asserted the cycle after the strobe is first sampled.
  - ACK raises wb_ack_o for exactly 1 cycle, then returns to IDLE. ack is therefore never high on two consecutive cycles.
  - Write commits on the ACK edge for each enabled lane only.
  - Read: wb_dat_o is loaded on the same edge wb_ack_o rises and holds until the next read.
  - If strobe drops before ACK, return to IDLE with no ack and no write.
  - Strobes during CLEAR stall with no ack until RUN.
  - A 4-byte access at a+0..a+3 wraps modulo DEPTH; e.g. a=DEPTH-2 touches DEPTH-2, DEPTH-1, 0, 1.
- MPU port:
  - mpu_req high in RUN: mpu_do is registered from mem[a..a+MPU_BYTES-1] (wrapping), and mpu_valid=1 next cycle.
  - mpu_req low: mpu_valid=0 next cycle and mpu_do holds its value.
  - Requests during CLEAR are dropped; mpu_valid stays 0.
  - Back-to-back requests give one result per cycle.
- Same-cycle MPU read and Wishbone write commit to overlapping bytes: the MPU gets the old data (read-before-write). The written data is visible to a fetch issued the following cycle.

Optional Feature:
- Macro: CHECKER_MEMORY_WB_ERR_EN.
- Defined:
  - Adds port wb_err_o (out, 1, reset 0).
  - An access with any wb_adr_i bit at or above ADDR_WIDTH set, or with a+3 beyond DEPTH-1, gets wb_err_o instead of wb_ack_o, with the same timing. No bytes are written and wb_dat_o is unchanged.
- Undefined: no such port; these addresses wrap as described above.

Decomposition:
- Package checker_memory_pkg:
  - FSM state encodings (CLEAR/RUN, IDLE/WAIT/ACK)
  - lane-swap function between Wishbone big-endian and memory little-endian order
  - localparams DEPTH=2**ADDR_WIDTH and CLR_WORDS=DEPTH/4
- One sub-module, checker_memory_wb_fsm: Wishbone state machine, latency counter, ack/err generation, commit strobe. Storage, clear sequencer and MPU port stay in the top module.

Test Plan:
- Reset then idle: clr_busy=1 for exactly 256 cycles (ADDR_WIDTH=10); every byte reads 0; mpu_req during that window gives mpu_valid=0.
- WB write 0x11223344 sel=0xF at a=0x10, WB_LATENCY=1: ack one cycle after strobe, lasting one cycle. MPU fetch at 0x10 gives mpu_do=0x????44332211 with bytes 0x14/0x15 = 0. WB read returns 0x11223344.
- Partial write sel=0x4 data 0xAABBCCDD at a=0x10 over the previous data: mem[0x11]=0xBB only, and WB read returns 0x11BB3344.
- Wrap: WB write 0xDEADBEEF at a=0x3FE: mem[0x3FE]=DE, [0x3FF]=AD, [0x000]=BE, [0x001]=EF. MPU fetch at 0x3FE gives mpu_do[31:0]=0xEFBEADDE. With CHECKER_MEMORY_WB_ERR_EN, wb_err_o=1 instead and memory is unchanged.
- WB_LATENCY=4: ack exactly 4 cycles after first strobe. Strobe dropped after 2 cycles gives no ack and no write. sys_rst pulsed in WAIT gives no ack and clear restarts at k=0.
- Collision: MPU fetch at 0x20 on the same cycle a WB write to 0x20 commits: old bytes returned; a fetch on the next cycle returns new bytes.
